// File: rtl/scr1_mul_pkg.sv
// Shared types and helpers for the sequential multiplier.
//   mul_state_e      : FSM encoding (IDLE -> COMP -> FIX -> DONE)
//   MUL_DIGIT_W_DEF  : default number of op2 bits retired per cycle
//   MUL_XLEN_MAX     : widest operand the helpers handle
//   abs_mag()        : magnitude of a sign-extended operand
package scr1_mul_pkg;

  typedef enum logic [1:0] {MUL_IDLE, MUL_COMP, MUL_FIX, MUL_DONE} mul_state_e;

  localparam int MUL_DIGIT_W_DEF = 4;
  localparam int MUL_XLEN_MAX    = 64;

  // val must already be sign-extended to MUL_XLEN_MAX when signed_flag is set,
  // so the sign lives in the top bit regardless of the caller's XLEN.
  // The most negative XLEN value yields its exact unsigned magnitude.
  function automatic logic [MUL_XLEN_MAX-1:0] abs_mag(input logic [MUL_XLEN_MAX-1:0] val,
                                                      input logic signed_flag);
    return (signed_flag && val[MUL_XLEN_MAX-1]) ? ('0 - val) : val;
  endfunction

endpackage

// File: rtl/scr1_mul_digit.sv
// One radix-2^DIGIT_W step of the multiplier (combinational):
//   acc_nxt = (acc << DIGIT_W) + mult * digit
// Kept separate so a pipelined or DSP-mapped variant can drop in.
//   acc     in  2*XLEN   running accumulator
//   mult    in  XLEN     multiplicand magnitude
//   digit   in  DIGIT_W  current multiplier digit
//   acc_nxt out 2*XLEN   updated accumulator
module scr1_mul_digit
  import scr1_mul_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = MUL_DIGIT_W_DEF
) (
  input  logic [2*XLEN-1:0]  acc,
  input  logic [XLEN-1:0]    mult,
  input  logic [DIGIT_W-1:0] digit,
  output logic [2*XLEN-1:0]  acc_nxt
);

  logic [XLEN+DIGIT_W-1:0] pp;

  assign pp      = {{DIGIT_W{1'b0}}, mult} * {{XLEN{1'b0}}, digit};
  // MSB digit first, so the accumulator never exceeds 2*XLEN bits.
  assign acc_nxt = (acc << DIGIT_W) + {{(XLEN-DIGIT_W){1'b0}}, pp};

endmodule

// File: rtl/scr1_pipe_mul_seq.sv
// Iterative RV32M/RV64M multiplier: DIGIT_W bits of op2 per cycle, MSB first,
// on unsigned magnitudes with a final conditional negate.
//   clk, rstn              clock, async active-low reset
//   req_valid/req_ready    operand handshake (ready only in IDLE)
//   op1, op2               operands; op1_signed/op2_signed select two's complement
//   flush                  abort anything in flight, overrides both handshakes
//   res_valid/res_ready    result handshake; res_hi/res_lo = 2*XLEN product
//   busy                   FSM not idle
module scr1_pipe_mul_seq
  import scr1_mul_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIGIT_W   = MUL_DIGIT_W_DEF,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            op1_signed,
  input  logic            op2_signed,
  input  logic            flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo,
  output logic            busy
);

  localparam int NDIG  = XLEN / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((XLEN % DIGIT_W) != 0 || XLEN > MUL_XLEN_MAX ||
        !(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 || DIGIT_W == 8)) begin : g_bad_cfg
      $error("scr1_pipe_mul_seq: illegal XLEN/DIGIT_W combination");
    end
  endgenerate

  mul_state_e state, state_nxt;

  logic [2*XLEN-1:0]       acc, acc_nxt;
  logic [XLEN-1:0]         m1, m2, m1_in, m2_in;
  logic                    neg;
  logic [CNT_W-1:0]        cnt;
  logic [MUL_XLEN_MAX-1:0] ext1, ext2;
  logic                    accept, early, last;

  // Sign-extend into the helper's fixed width, then take the magnitude.
  always_comb begin
    ext1            = {MUL_XLEN_MAX{op1_signed & op1[XLEN-1]}};
    ext1[XLEN-1:0]  = op1;
    ext2            = {MUL_XLEN_MAX{op2_signed & op2[XLEN-1]}};
    ext2[XLEN-1:0]  = op2;
    m1_in           = XLEN'(abs_mag(ext1, op1_signed));
    m2_in           = XLEN'(abs_mag(ext2, op2_signed));
  end

  assign accept = (state == MUL_IDLE) && req_valid && !flush;
  assign early  = EARLY_OUT && ((m1_in == '0) || (m2_in == '0));
  assign last   = (cnt == CNT_W'(NDIG - 1));

  scr1_mul_digit #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) u_digit (
    .acc     (acc),
    .mult    (m1),
    .digit   (m2[XLEN-1 -: DIGIT_W]),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= MUL_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = MUL_IDLE;
    end else begin
      case (state)
        MUL_IDLE: if (req_valid) state_nxt = early ? MUL_DONE : MUL_COMP;
        MUL_COMP: if (last)      state_nxt = MUL_FIX;
        MUL_FIX:                 state_nxt = MUL_DONE;
        MUL_DONE: if (res_ready) state_nxt = MUL_IDLE;
        default:                 state_nxt = MUL_IDLE;
      endcase
    end
  end

  // m2 is shifted left each COMP cycle so the live digit is always on top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      m1  <= '0;
      m2  <= '0;
      neg <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= '0;
      m1  <= m1_in;
      m2  <= m2_in;
      neg <= (op1_signed & op1[XLEN-1]) ^ (op2_signed & op2[XLEN-1]);
      cnt <= '0;
    end else if (!flush) begin
      if (state == MUL_COMP) begin
        acc <= acc_nxt;
        m2  <= m2 << DIGIT_W;
        cnt <= cnt + CNT_W'(1);
      end else if (state == MUL_FIX && neg) begin
        acc <= '0 - acc;
      end
    end
  end

  assign req_ready = (state == MUL_IDLE);
  assign busy      = (state != MUL_IDLE);
  assign res_valid = (state == MUL_DONE);
  assign res_hi    = acc[2*XLEN-1:XLEN];
  assign res_lo    = acc[XLEN-1:0];

endmodule

// File: tb/tb_scr1_pipe_mul_seq.sv
// Directed bench for scr1_pipe_mul_seq: a default-configured DUT with full
// handshake control, plus three variants (EARLY_OUT=0, DIGIT_W=1, XLEN=64)
// sharing one request bus with res_ready tied high.
module tb_scr1_pipe_mul_seq;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // default DUT
  logic        req_valid, req_ready, op1_signed, op2_signed, flush;
  logic        res_valid, res_ready, busy;
  logic [31:0] op1, op2, res_hi, res_lo;

  // shared request bus for the variants
  logic        e_req_valid, e_s1, e_s2;
  logic [63:0] e_op1, e_op2;

  logic        ne_rdy, ne_vld, ne_busy, d1_rdy, d1_vld, d1_busy, x_rdy, x_vld, x_busy;
  logic [31:0] ne_hi, ne_lo, d1_hi, d1_lo;
  logic [63:0] x_hi, x_lo;

  int vec  = 0;
  int errs = 0;

  scr1_pipe_mul_seq dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .op1(op1), .op2(op2), .op1_signed(op1_signed), .op2_signed(op2_signed),
    .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .busy(busy)
  );

  scr1_pipe_mul_seq #(.XLEN(32), .DIGIT_W(4), .EARLY_OUT(1'b0)) u_ne (
    .clk(clk), .rstn(rstn), .req_valid(e_req_valid), .req_ready(ne_rdy),
    .op1(e_op1[31:0]), .op2(e_op2[31:0]), .op1_signed(e_s1), .op2_signed(e_s2),
    .flush(1'b0), .res_valid(ne_vld), .res_ready(1'b1),
    .res_hi(ne_hi), .res_lo(ne_lo), .busy(ne_busy)
  );

  scr1_pipe_mul_seq #(.XLEN(32), .DIGIT_W(1), .EARLY_OUT(1'b1)) u_d1 (
    .clk(clk), .rstn(rstn), .req_valid(e_req_valid), .req_ready(d1_rdy),
    .op1(e_op1[31:0]), .op2(e_op2[31:0]), .op1_signed(e_s1), .op2_signed(e_s2),
    .flush(1'b0), .res_valid(d1_vld), .res_ready(1'b1),
    .res_hi(d1_hi), .res_lo(d1_lo), .busy(d1_busy)
  );

  scr1_pipe_mul_seq #(.XLEN(64), .DIGIT_W(8), .EARLY_OUT(1'b1)) u_x64 (
    .clk(clk), .rstn(rstn), .req_valid(e_req_valid), .req_ready(x_rdy),
    .op1(e_op1), .op2(e_op2), .op1_signed(e_s1), .op2_signed(e_s2),
    .flush(1'b0), .res_valid(x_vld), .res_ready(1'b1),
    .res_hi(x_hi), .res_lo(x_lo), .busy(x_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  // Accept one op on the default DUT, measure latency, check product, handshake.
  task automatic run_main(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; op1 = a; op2 = b; op1_signed = sa; op2_signed = sb;
    @(posedge clk); #1;
    req_valid = 1'b0; op1 = ~a; op2 = ~b; op1_signed = ~sa; op2_signed = ~sb;
    lat = 1;
    while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, " lat"}, 128'(lat), 128'(exp_lat));
    check({tag, " prod"}, {64'h0, res_hi, res_lo}, {64'h0, exp});
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  // One op on all three variants at once.
  task automatic run_ext(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic sa, input logic sb,
                         input logic [63:0] exp_ne, input int lat_ne,
                         input logic [63:0] exp_d1, input int lat_d1,
                         input logic [127:0] exp_x, input int lat_x);
    int n;
    int l_ne = 0, l_d1 = 0, l_x = 0;
    logic [63:0]  p_ne = '0, p_d1 = '0;
    logic [127:0] p_x = '0;
    @(negedge clk);
    e_req_valid = 1'b1; e_op1 = a; e_op2 = b; e_s1 = sa; e_s2 = sb;
    @(posedge clk); #1;
    e_req_valid = 1'b0; e_op1 = ~a; e_op2 = ~b; e_s1 = ~sa; e_s2 = ~sb;
    n = 1;
    while (n < 60) begin
      if (ne_vld && l_ne == 0) begin l_ne = n; p_ne = {ne_hi, ne_lo}; end
      if (d1_vld && l_d1 == 0) begin l_d1 = n; p_d1 = {d1_hi, d1_lo}; end
      if (x_vld  && l_x  == 0) begin l_x  = n; p_x  = {x_hi, x_lo};   end
      if (l_ne != 0 && l_d1 != 0 && l_x != 0) break;
      @(posedge clk); #1; n++;
    end
    check({tag, " ne lat"}, 128'(l_ne), 128'(lat_ne));
    check({tag, " ne prod"}, {64'h0, p_ne}, {64'h0, exp_ne});
    check({tag, " d1 lat"}, 128'(l_d1), 128'(lat_d1));
    check({tag, " d1 prod"}, {64'h0, p_d1}, {64'h0, exp_d1});
    check({tag, " x64 lat"}, 128'(l_x), 128'(lat_x));
    check({tag, " x64 prod"}, p_x, exp_x);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    logic seen;
    req_valid = 1'b0; op1 = '0; op2 = '0; op1_signed = 1'b0; op2_signed = 1'b0;
    flush = 1'b0; res_ready = 1'b0;
    e_req_valid = 1'b0; e_op1 = '0; e_op2 = '0; e_s1 = 1'b0; e_s2 = 1'b0;

    #12;
    check("reset state", {req_ready, res_valid, busy, res_hi, res_lo}, {3'b100, 64'h0});
    check("reset variants", {ne_rdy, ne_vld, ne_busy, d1_rdy, d1_vld, d1_busy, x_rdy, x_vld, x_busy},
          9'b100_100_100);
    @(negedge clk); rstn = 1'b1;

    // res_ready with nothing to deliver is ignored
    res_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("idle res_ready", {req_ready, res_valid, busy}, 3'b100);
    res_ready = 1'b0;

    run_main("7x6 u",      32'h0000_0007, 32'h0000_0006, 1'b0, 1'b0, 64'h0000_0000_0000_002A, 10);
    run_main("m1x3 s",     32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 10);
    run_main("m1x3 u",     32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0, 64'h0000_0002_FFFF_FFFD, 10);
    run_main("min sq s",   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, 10);
    run_main("mulhsu",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_8000_0000, 10);
    run_main("op2 zero",   32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 64'h0, 1);

    // flush beats req_valid in IDLE
    @(negedge clk); req_valid = 1'b1; flush = 1'b1; op1 = 32'd9; op2 = 32'd9;
    @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
    check("flush vs req", {req_ready, busy}, 2'b10);

    // flush in the fourth COMP cycle
    @(negedge clk); req_valid = 1'b1; op1 = 32'd9; op2 = 32'd9;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush idle", {req_ready, busy, res_valid}, 3'b100);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; seen = seen | res_valid; end
    check("flush no result", 128'(seen), 128'(0));
    run_main("3x5 after flush", 32'd3, 32'd5, 1'b0, 1'b0, 64'd15, 10);

    // back-pressure in DONE: result holds, new requests are not taken
    @(negedge clk); req_valid = 1'b1; op1 = 32'h10; op2 = 32'h10; op1_signed = 1'b0; op2_signed = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("stall lat", 128'(n), 128'(10));
    @(negedge clk); req_valid = 1'b1; op1 = 32'd5; op2 = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall hold", {res_valid, req_ready, res_hi, res_lo}, {2'b10, 64'h100});
    end
    @(negedge clk); req_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    check("post handshake", {req_ready, res_valid, busy}, 3'b100);

    // async reset in the middle of COMP
    @(negedge clk); req_valid = 1'b1; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b0; #1;
    check("async reset", {req_ready, res_valid, busy, res_hi, res_lo}, {3'b100, 64'h0});
    #2; rstn = 1'b1;
    @(posedge clk); #1;
    check("after reset", {req_ready, busy, res_valid}, 3'b100);

    run_ext("v 7x6", 64'd7, 64'd6, 1'b0, 1'b0,
            64'h2A, 10, 64'h2A, 34, 128'h2A, 10);
    run_ext("v zero", 64'd5, 64'd0, 1'b0, 1'b0,
            64'h0, 10, 64'h0, 1, 128'h0, 1);
    run_ext("v m1x3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFD, 10, 64'hFFFF_FFFF_FFFF_FFFD, 34,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD, 10);
    run_ext("v min sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
            64'h0, 10, 64'h0, 1, 128'h4000_0000_0000_0000_0000_0000_0000_0000, 10);
    run_ext("v max u", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
            64'hFFFF_FFFE_0000_0001, 10, 64'hFFFF_FFFE_0000_0001, 34,
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 10);
    run_ext("v mulhsu", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
            64'h0, 10, 64'h0, 1, 128'h8000_0000_0000_0000_8000_0000_0000_0000, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
